mem_initiator: RTL
==================

MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, giving the maximum number of cycles spent waiting on mem_clk_stall before aborting.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: the core presents a load/store request.
REQ-005 The block SHALL have port req_ready, output, 1 bit: high only in IDLE; a request is accepted on req_valid & req_ready.
REQ-006 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port req_funct3, input, 3 bits: the RV32I funct3 width/sign code.
REQ-008 The block SHALL have ports req_addr and req_wdata, input, 32 bits each: the byte address and the store data (store data right-aligned).
REQ-009 The block SHALL have port resp_valid, output, 1 bit: a one-cycle completion pulse.
REQ-010 The block SHALL have port resp_rdata, output, 32 bits: load result, valid with resp_valid; 0 for stores and errors.
REQ-011 The block SHALL have port resp_err, output, 2 bits: 00 ok, 01 misaligned, 10 illegal funct3, 11 timeout.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 The block SHALL have ports mem_addr and mem_write_data, output, 32 bits each: toward the data memory.
REQ-014 The block SHALL have ports mem_memread, mem_memwrite, output, 1 bit each: single-cycle access strobes.
REQ-015 The block SHALL have port mem_sign_mask, output, 4 bits: bit3 = sign-extend; [2:0] = 001 byte, 011 half, 111 word.
REQ-016 The block SHALL have port mem_read_data, input, 32 bits: the already-extracted and extended load data from the memory.
REQ-017 The block SHALL have port mem_clk_stall, input, 1 bit: the memory busy indication.

Function
REQ-018 The block SHALL implement the states IDLE, ISSUE, WAIT_HI, WAIT_LO and RESP, with all outputs registered.
REQ-019 Decode SHALL map loads LB/LH/LW/LBU/LHU (000/001/010/100/101) to mem_sign_mask 1001/1011/0111/0001/0011.
REQ-020 Decode SHALL map stores SB/SH/SW (000/001/010) to mem_sign_mask 0001/0011/0111; any other funct3 is illegal.
REQ-021 Alignment SHALL be checked on acceptance: half with addr[0]=1 or word with addr[1:0]!=00 is misaligned.
REQ-022 Byte accesses SHALL never be misaligned.
REQ-023 On acceptance of an illegal or misaligned request, the block SHALL go IDLE->RESP with no memory strobe; illegal funct3 takes priority over misaligned.
REQ-024 On acceptance of a legal request, the block SHALL go IDLE->ISSUE.
REQ-025 In ISSUE, the block SHALL drive for exactly one cycle: mem_addr=req_addr, mem_write_data=req_wdata, the decoded mask, and mem_memread=~we or mem_memwrite=we.
REQ-026 The block SHALL then go to WAIT_HI.
REQ-027 mem_addr, mem_write_data and mem_sign_mask SHALL hold their values until the next ISSUE.
REQ-028 Strobes SHALL never be high for more than one consecutive cycle.
REQ-029 mem_memread and mem_memwrite SHALL never be high together.
REQ-030 WAIT_HI: mem_clk_stall=1 SHALL take the block to WAIT_LO.
REQ-031 WAIT_LO: mem_clk_stall=0 SHALL take the block to RESP; for a load, mem_read_data is captured into resp_rdata on that edge.
REQ-032 A single timeout counter SHALL clear at ISSUE and increment each cycle in WAIT_HI or WAIT_LO; at count == TIMEOUT it forces RESP with err 11 and resp_rdata 0.
REQ-033 The counter SHALL saturate and never wrap.
REQ-034 RESP SHALL assert resp_valid for one cycle, then go to IDLE; req_ready is 0 during RESP, so back-to-back requests are spaced 5 cycles apart (accept-to-accept).
REQ-035 Nominal latency SHALL be acceptance edge to resp_valid high = 4 cycles (ISSUE, WAIT_HI, WAIT_LO, RESP); for an error request, resp_valid SHALL rise 1 cycle after acceptance.
REQ-036 req_* inputs SHALL be sampled only at acceptance; later changes have no effect on the request in flight.

Reset
REQ-037 While reset is high, the block SHALL be in IDLE, and req_ready=1 after reset deassertion.
REQ-038 While reset is high, resp_valid, resp_err, resp_rdata, busy, mem_memread, mem_memwrite, mem_addr, mem_write_data and mem_sign_mask SHALL all be 0, and the counter SHALL be 0.
REQ-039 Reset asserted mid-transaction SHALL abort it immediately, with no resp_valid for the aborted request.

Verification
REQ-040 LB at addr 0x1003, memory returns 0xFFFFFF80: mask 1001 on the strobe; resp_valid 4 cycles after acceptance; rdata 0xFFFFFF80; err 00.
REQ-041 SW at 0x1004, data 0xDEADBEEF: mem_memwrite high 1 cycle; mem_write_data 0xDEADBEEF; mask 0111; resp_err 00; resp_rdata 0.
REQ-042 LH at 0x1001: no strobe; resp_valid 1 cycle after acceptance; err 01. Load funct3 011: err 10.
REQ-043 LW with mem_clk_stall held 0: resp_valid 15 cycles after WAIT_HI entry; err 11; rdata 0.
REQ-044 Reset pulsed during WAIT_LO: busy=0 and req_ready=1 after deassertion; no resp_valid; a new LBU at 0x1000 returning 0x000000AB then completes normally.
REQ-045 Two back-to-back requests with req_valid held high: accepts 5 cycles apart; strobes never adjacent or overlapping.

Source files
------------

// File: rtl/mem_initiator.sv
// Load/store initiator between an RV32I core and a stalling data memory.
// It takes one request at a time, checks funct3 and alignment, and gives
// each legal request a single-cycle strobe. It then follows the memory's
// stall handshake, or times out, and returns a one-cycle response.
module mem_initiator #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT_HI = 3'd2;
  localparam logic [2:0] S_WAIT_LO = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam int            CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  logic [2:0]    state, state_next;
  logic [CW-1:0] cnt, cnt_inc;
  logic          timeout_hit;
  logic          accept, issue_go;
  logic          dec_legal, dec_misal;
  logic [3:0]    dec_mask;
  logic          we_q;
  logic [1:0]    err_next;
  logic [31:0]   rdata_next;

  assign accept = req_valid & req_ready;

  // Decode funct3 into the memory width/sign mask and check alignment.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    dec_legal = 1'b1;
    dec_mask  = 4'b0000;
    if (req_we) begin
      case (req_funct3)
        3'b000:  dec_mask = 4'b0001;
        3'b001:  dec_mask = 4'b0011;
        3'b010:  dec_mask = 4'b0111;
        default: dec_legal = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        3'b000:  dec_mask = 4'b1001;
        3'b001:  dec_mask = 4'b1011;
        3'b010:  dec_mask = 4'b0111;
        3'b100:  dec_mask = 4'b0001;
        3'b101:  dec_mask = 4'b0011;
        default: dec_legal = 1'b0;
      endcase
    end
    // Byte accesses can never be misaligned.
    dec_misal = ((dec_mask[2:0] == 3'b011) && req_addr[0]) ||
                ((dec_mask[2:0] == 3'b111) && (req_addr[1:0] != 2'b00));
  end

  // Saturating next count; reaching TIMEOUT ends the wait.
  always_comb begin
    cnt_inc     = (cnt == TMO) ? cnt : cnt + 1'b1;
    timeout_hit = (cnt_inc == TMO);
  end

  // Next state, plus the error code and read data that go with entering RESP.
  always_comb begin
    state_next = state;
    err_next   = ERR_OK;
    rdata_next = '0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!dec_legal) begin
            state_next = S_RESP;
            err_next   = ERR_ILLEGAL;
          end else if (dec_misal) begin
            state_next = S_RESP;
            err_next   = ERR_MISALIGN;
          end else begin
            state_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_next = S_WAIT_HI;
      S_WAIT_HI: begin
        if (timeout_hit) begin
          state_next = S_RESP;
          err_next   = ERR_TIMEOUT;
        end else if (mem_clk_stall) begin
          state_next = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        // A completing memory wins over a timeout on the same cycle.
        if (!mem_clk_stall) begin
          state_next = S_RESP;
          rdata_next = we_q ? 32'h0 : mem_read_data;
        end else if (timeout_hit) begin
          state_next = S_RESP;
          err_next   = ERR_TIMEOUT;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign issue_go = (state == S_IDLE) && (state_next == S_ISSUE);

  // State register, wait counter and captured request direction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      we_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state <= state_next;
      if (state == S_ISSUE) begin
        cnt <= '0;
      end else if ((state == S_WAIT_HI) || (state == S_WAIT_LO)) begin
        cnt <= cnt_inc;
      end
      if (accept) begin
        we_q <= req_we;
      end
    end
  end

  // Memory side: address/data/mask load once per legal request and hold; strobes last one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_sign_mask  <= '0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
    end else begin
      mem_memread  <= issue_go & ~req_we;
      mem_memwrite <= issue_go & req_we;
      if (issue_go) begin
        mem_addr       <= req_addr;
        mem_write_data <= req_wdata;
        mem_sign_mask  <= dec_mask;
      end
    end
  end

  // Core side: response pulse with its result, plus the ready and busy flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_err   <= ERR_OK;
      resp_rdata <= '0;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      resp_valid <= (state_next == S_RESP);
      busy       <= (state_next != S_IDLE);
      req_ready  <= (state_next == S_IDLE);
      if (state_next == S_RESP) begin
        resp_err   <= err_next;
        resp_rdata <= rdata_next;
      end
    end
  end

endmodule
